// File: rtl/invsqrt_pkg.sv
// Shared widths for the Q12.4 inverse-square-root path (wrapper, queue, core).
package invsqrt_pkg;
  localparam int INT_WIDTH   = 12;
  localparam int FRACT_WIDTH = 4;
  localparam int DATA_WIDTH  = INT_WIDTH + FRACT_WIDTH;
  localparam int DROP_CNT_W  = 8;

  typedef logic [DATA_WIDTH-1:0] operand_t;
endpackage

// File: rtl/invsqrt_req_queue.sv
// Operand queue in front of the inverse-square-root core: first-word-fall-through
// circular FIFO with level, full/empty, sticky overflow and saturating drop count.
module invsqrt_req_queue
  import invsqrt_pkg::*;
#(
  parameter int DATA_WIDTH = invsqrt_pkg::DATA_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overflow_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("invsqrt_req_queue: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] drop_cnt;

  logic pop;
  logic accept;
  logic drop;

  // Status and handshake decode; outputs depend only on registered state.
  always_comb begin
    empty_o    = (level == '0);
    full_o     = (level == LW'(DEPTH));
    valid_o    = !empty_o;
    data_o     = mem[rd_ptr];
    level_o    = level;
    overflow_o = overflow;
    drop_cnt_o = drop_cnt;
    // A pop frees a slot in the same cycle, so a full queue still takes a push.
    pop        = valid_o && ready_i;
    accept     = push_i && (!full_o || pop);
    drop       = push_i && full_o && !pop;
  end

  // Storage, pointers, level and sticky status; reset beats flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (flush_i) begin
      // mem is left as-is; only the bookkeeping is cleared.
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_data_i;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (accept && !pop)      level <= level + LW'(1);
      else if (pop && !accept) level <= level - LW'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_invsqrt_req_queue.sv
// Randomised self-checking bench for invsqrt_req_queue against a queue-based model.
module tb_invsqrt_req_queue;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_i;
  logic [DW-1:0] push_data_i;
  logic          flush_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic [3:0]    level_o;
  logic          empty_o;
  logic          full_o;
  logic          overflow_o;
  logic [7:0]    drop_cnt_o;

  invsqrt_req_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push_i(push_i), .push_data_i(push_data_i),
    .flush_i(flush_i), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .level_o(level_o), .empty_o(empty_o), .full_o(full_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [DW-1:0] mq[$];
  bit            m_ovf;
  int            m_cnt;

  int checks = 0;
  int passed = 0;

  // Observed status with data masked when no head is presented.
  logic [31:0] dut_vec;
  assign dut_vec = {valid_o, (valid_o ? data_o : 16'h0), level_o, empty_o,
                    full_o, overflow_o, drop_cnt_o};

  function automatic logic [31:0] exp_vec();
    logic          v;
    logic [DW-1:0] d;
    int            n;
    n = mq.size();
    v = (n != 0);
    d = v ? mq[0] : 16'h0;
    return {v, d, 4'(n), (n == 0), (n == DEPTH), m_ovf, 8'(m_cnt)};
  endfunction

  // Apply one cycle of inputs, advance the model, and land 1 time unit past the edge.
  task automatic step(input bit p, input logic [DW-1:0] d, input bit r,
                      input bit f, input bit rs);
    bit full, pop, acc;
    push_i = p; push_data_i = d; ready_i = r; flush_i = f; rst = rs;
    if (rs || f) begin
      mq.delete(); m_ovf = 0; m_cnt = 0;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && r;
      acc  = p && (!full || pop);
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(d);
      if (p && full && !pop) begin
        m_ovf = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    push_i = 0; ready_i = 0; flush_i = 0; rst = 0;
  endtask

  task automatic test_reset();
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 0, 0);
      checks++;
      if (dut_vec !== exp_vec() || data_o !== 16'h0)
        $display("FAIL reset_idle cycle %0d: got %h data %h want %h data 0000",
                 i, dut_vec, data_o, exp_vec());
      else passed++;
    end
  endtask

  task automatic test_single_hold();
    step(1, 16'h0040, 0, 0, 0);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 16'h0040 || level_o !== 4'd1)
      $display("FAIL single_push: got v=%b d=%h l=%0d want v=1 d=0040 l=1",
               valid_o, data_o, level_o);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if (dut_vec !== exp_vec())
        $display("FAIL single_hold cycle %0d: got %h want %h", i, dut_vec, exp_vec());
      else passed++;
    end
    step(0, 0, 1, 0, 0);
    checks++;
    if (empty_o !== 1'b1 || dut_vec !== exp_vec())
      $display("FAIL single_pop: got %h want %h", dut_vec, exp_vec());
    else passed++;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) step(1, 16'(i * 16), 0, 0, 0);
    checks++;
    if (full_o !== 1'b1 || level_o !== 4'd8 || dut_vec !== exp_vec())
      $display("FAIL fill_full: got %h want %h", dut_vec, exp_vec());
    else passed++;
    step(1, 16'h0090, 0, 0, 0);
    checks++;
    if (overflow_o !== 1'b1 || drop_cnt_o !== 8'd1 || level_o !== 4'd8)
      $display("FAIL overflow_drop: got ovf=%b cnt=%0d l=%0d want ovf=1 cnt=1 l=8",
               overflow_o, drop_cnt_o, level_o);
    else passed++;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (valid_o !== 1'b1 || data_o !== 16'(i * 16))
        $display("FAIL drain_order %0d: got v=%b d=%h want v=1 d=%h",
                 i, valid_o, data_o, 16'(i * 16));
      else passed++;
      step(0, 0, 1, 0, 0);
    end
    checks++;
    if (valid_o !== 1'b0 || dut_vec !== exp_vec())
      $display("FAIL drain_empty: got %h want %h", dut_vec, exp_vec());
    else passed++;
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) step(1, 16'($urandom), 0, 0, 0);
    step(1, 16'h00A0, 1, 0, 0);
    checks++;
    if (level_o !== 4'd8 || dut_vec !== exp_vec())
      $display("FAIL full_push_pop: got %h want %h", dut_vec, exp_vec());
    else passed++;
    for (int i = 0; i < 20; i++) begin
      step(1, 16'($urandom), 1, 0, 0);
      checks++;
      if (dut_vec !== exp_vec())
        $display("FAIL wrap_stream %0d: got %h want %h", i, dut_vec, exp_vec());
      else passed++;
    end
    while (mq.size() != 0) begin
      step(0, 0, 1, 0, 0);
      checks++;
      if (dut_vec !== exp_vec())
        $display("FAIL wrap_drain: got %h want %h", dut_vec, exp_vec());
      else passed++;
    end
  endtask

  task automatic test_flush();
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 16'($urandom), 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 16'($urandom), 0, 0, 0);
    checks++;
    if (drop_cnt_o !== 8'd3 || dut_vec !== exp_vec())
      $display("FAIL flush_pre: got %h want %h", dut_vec, exp_vec());
    else passed++;
    step(1, 16'hBEEF, 1, 1, 0);
    checks++;
    if (level_o !== 4'd0 || valid_o !== 1'b0 || overflow_o !== 1'b0 || drop_cnt_o !== 8'd0)
      $display("FAIL flush_clear: got l=%0d v=%b ovf=%b cnt=%0d want 0 0 0 0",
               level_o, valid_o, overflow_o, drop_cnt_o);
    else passed++;
    step(1, 16'h1234, 0, 0, 0);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 16'h1234 || level_o !== 4'd1)
      $display("FAIL flush_recover: got v=%b d=%h l=%0d want v=1 d=1234 l=1",
               valid_o, data_o, level_o);
    else passed++;
    step(0, 0, 1, 0, 0);
  endtask

  task automatic test_saturate_reset();
    for (int i = 0; i < 8; i++) step(1, 16'($urandom), 0, 0, 0);
    for (int i = 0; i < 300; i++) step(1, 16'($urandom), 0, 0, 0);
    checks++;
    if (drop_cnt_o !== 8'd255 || dut_vec !== exp_vec())
      $display("FAIL drop_saturate: got %h want %h", dut_vec, exp_vec());
    else passed++;
    step(1, 16'($urandom), 1, 1, 1);
    checks++;
    if (dut_vec !== exp_vec() || data_o !== 16'h0 || empty_o !== 1'b1)
      $display("FAIL mid_reset: got %h data %h want %h data 0000",
               dut_vec, data_o, exp_vec());
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 3) != 0, 16'($urandom), ($urandom % 2) == 0,
           ($urandom % 40) == 0, 0);
      checks++;
      if (dut_vec !== exp_vec())
        $display("FAIL random %0d: got %h want %h", i, dut_vec, exp_vec());
      else passed++;
    end
  endtask

  initial begin
    rst = 1; push_i = 0; push_data_i = 0; flush_i = 0; ready_i = 0;
    m_ovf = 0; m_cnt = 0;
    #1;
    test_reset();
    test_single_hold();
    test_fill_overflow();
    test_full_push_pop();
    test_flush();
    test_saturate_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/invsqrt_req_queue.md
# invsqrt_req_queue

Request queue directly upstream of the Q12.4 fast inverse-square-root core. It accepts one-cycle push strobes from the Wishbone wrapper and buffers operands in a circular FIFO. It presents them to the core's valid/ready input handshake, so software can post a burst of operands without waiting for each result. It also provides level, full/empty and overflow status for the wrapper's status register.

## Interface
- DATA_WIDTH, 16, operand width (Q12.4: 12 integer, 4 fraction bits)
- DEPTH, 8, number of entries; power of two, ≥ 2
- LW, $clog2(DEPTH)+1, level width (derived localparam, not overridable)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- push_i  in  1  push strobe; one operand per cycle asserted
- push_data_i  in  DATA_WIDTH  operand to enqueue
- flush_i  in  1  synchronous clear of queue contents and sticky status
- data_o  out  DATA_WIDTH  head operand, to core data_in
- valid_o  out  1  head valid, to core valid_in
- ready_i  in  1  core ready_in; pop occurs when valid_o && ready_i
- level_o  out  LW  entries currently held, 0..DEPTH
- empty_o  out  1  level_o == 0
- full_o  out  1  level_o == DEPTH
- overflow_o  out  1  sticky: at least one push dropped
- drop_cnt_o  out  8  dropped-push count, saturating at 255

## Operation
- Storage is a flop array mem[DEPTH] with rd_ptr and wr_ptr (log2(DEPTH) bits each) and a level counter (LW bits). Pointers wrap modulo DEPTH by natural overflow.
- Read is first-word-fall-through: data_o = mem[rd_ptr] and valid_o = !empty_o. No combinational path from push_i or ready_i to any output.
- pop = valid_o && ready_i. On pop, rd_ptr advances.
- Push acceptance: accept = push_i && (!full_o || pop). On accept, mem[wr_ptr] ← push_data_i and wr_ptr advances.
- Level update: level += accept − pop.
- Simultaneous push and pop:
  - When full, the push is accepted and the level stays at DEPTH.
  - When the level is 1, the new word becomes the head next cycle.
- Drop: push_i && full_o && !pop.
  - The push is discarded and overflow_o ← 1.
  - drop_cnt_o increments unless already at 255.
  - Stored data and pointers are unchanged.
- Flush:
  - rd_ptr, wr_ptr and level go to 0.
  - overflow_o and drop_cnt_o are cleared.
  - Flush has priority over push and pop in the same cycle: the push is discarded and not counted as a drop, and no pop is recorded.
  - mem contents are not cleared.
- Holding rule: while valid_o && !ready_i, data_o and valid_o stay stable until the pop occurs.

## Timing
- Reset values:
  - valid_o 0, empty_o 1, full_o 0, level_o 0
  - overflow_o 0, drop_cnt_o 0
  - data_o 0: mem is reset to zero and pointers to 0.
- Latency:
  - A push into an empty queue at edge N gives valid_o=1 and data_o=operand after edge N.
  - A pop at edge N shows the next head, or valid_o=0, after edge N.
- Throughput: one push and one pop per cycle, sustained, at any level.
- Status outputs (level, empty, full, overflow, drop count) all update on the same edge as the event that causes them.
- Reset mid-operation: on the edge where rst is high, all state returns to reset values regardless of push_i, ready_i or flush_i. Any in-flight head is abandoned; the wrapper resets the core alongside.
- Flush recovery: a flush at edge N gives valid_o=0 after N. A push at N+1 gives valid_o=1 after N+1.

## Structure
- Shared package invsqrt_pkg holds:
  - INT_WIDTH=12, FRACT_WIDTH=4 and DATA_WIDTH=INT_WIDTH+FRACT_WIDTH
  - DROP_CNT_W=8
- The wrapper and core import the same package.
- Single module; pointer, level and status logic are inline. No sub-module: the storage is small enough to stay local.
- Elaboration-time assertion that DEPTH is a power of two and ≥ 2.

## Test plan
All scenarios use DEPTH=8.
- Reset then idle, ready_i=1 → valid_o=0, empty_o=1, level_o=0, data_o=0 for 20 cycles.
- Push 0x0040 (4.0) at edge 1, ready_i=0 → after edge 1 valid_o=1, data_o=0x0040, level_o=1. Held stable 5 cycles; ready_i=1 pops it on the next edge → empty_o=1.
- Push 8 operands 0x0010..0x0080 with ready_i=0 → full_o=1, level_o=8. 9th push 0x0090 → overflow_o=1, drop_cnt_o=1, level stays 8. Drain → outputs 0x0010..0x0080 in order, 0x0090 absent.
- Full queue, push 0x00A0 with ready_i=1 in the same cycle → no drop, level_o stays 8, 0x00A0 emerges last. Then 20 push/pop cycles continuous → pointer wrap, order preserved.
- Full queue with drop_cnt_o=3, assert flush_i with push_i=1 → next cycle level_o=0, valid_o=0, overflow_o=0, drop_cnt_o=0. The pushed word never appears.
- 300 dropped pushes on a full queue → drop_cnt_o saturates at 255. rst mid-stream → all outputs at reset values after that edge.
